// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader: FSM state encoding,
// word geometry and the word-address step.
package loader_pkg;

    localparam int WORD_BYTES  = 4;
    localparam int INSTR_WIDTH = 32;
    localparam int ADDR_STEP   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_RELEASE,
        ST_ERROR
    } state_t;

    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + 32'(ADDR_STEP);
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Valid/ready program byte stream feeding the loader; the source drives master,
// the loader consumes through slave.
interface instr_mem_loader_if;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_last;
    logic       byte_ready;

    modport master (
        output byte_valid,
        output byte_data,
        output byte_last,
        input  byte_ready
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        input  byte_last,
        output byte_ready
    );

endinterface

// File: rtl/instr_mem_loader_byte_packer.sv
// Packs accepted bytes into big-endian 32-bit words: first byte of a word lands in [31:24].
// Flags the byte that completes a word and a byte_last that arrives too early.
module byte_packer
    import loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   accept,
    input  logic [7:0]             byte_data,
    input  logic                   byte_last,
    output logic [INSTR_WIDTH-1:0] word,
    output logic                   word_full,
    output logic                   last_early,
    output logic                   last_seen
);

    logic [INSTR_WIDTH-1:0] shift_q;
    logic [1:0]             cnt_q;

    // word already includes the byte being accepted, so the top can latch it on the same edge
    assign word       = {shift_q[INSTR_WIDTH-9:0], byte_data};
    assign word_full  = accept && (cnt_q == 2'(WORD_BYTES - 1));
    assign last_early = accept && byte_last && !word_full;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            last_seen <= 1'b0;
        end else if (accept) begin
            shift_q <= word;
            cnt_q   <= cnt_q + 2'd1;
            if (byte_last) begin
                last_seen <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a byte-streamed program into CPU instruction memory one word at a time,
// holding the CPU in reset until the final word has been written.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'd0,
    parameter int          MAX_WORDS   = 64,
    parameter int          HOLD_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    instr_mem_loader_if.slave      bus,
    output logic                   initialize,
    output logic [INSTR_WIDTH-1:0] instruction_initialize_data,
    output logic [31:0]            instruction_initialize_address,
    output logic                   cpu_rst,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int WW = $clog2(MAX_WORDS + 1);

    state_t                 state_q, state_d;
    logic [HW-1:0]          hold_q;
    logic [WW-1:0]          words_q;
    logic [31:0]            wr_addr_q;
    logic [31:0]            addr_q;
    logic [INSTR_WIDTH-1:0] data_q;
    logic                   loaded_q;

    logic                   accept;
    logic                   start_ok;
    logic                   hold_end;
    logic [INSTR_WIDTH-1:0] packed_word;
    logic                   word_full;
    logic                   last_early;
    logic                   last_seen;

    assign bus.byte_ready = (state_q == ST_COLLECT);
    assign accept         = bus.byte_valid && bus.byte_ready;
    assign start_ok       = start && ((state_q == ST_IDLE) || (state_q == ST_ERROR));
    assign hold_end       = (state_q == ST_WRITE) && (hold_q == HW'(HOLD_CYCLES - 1));

    assign instruction_initialize_data    = data_q;
    assign instruction_initialize_address = addr_q;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .accept     (accept),
        .byte_data  (bus.byte_data),
        .byte_last  (bus.byte_last),
        .word       (packed_word),
        .word_full  (word_full),
        .last_early (last_early),
        .last_seen  (last_seen)
    );

    // NOTE: every output of this block gets a default before the case, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        initialize = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_rst    = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                cpu_rst = ~loaded_q;
                if (start) state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                busy = 1'b1;
                if (last_early)     state_d = ST_ERROR;
                else if (word_full) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                busy       = 1'b1;
                initialize = 1'b1;
                // a final word that also fills memory completes normally
                if (hold_end) begin
                    if (last_seen)                            state_d = ST_RELEASE;
                    else if (words_q == WW'(MAX_WORDS - 1))   state_d = ST_ERROR;
                    else                                      state_d = ST_COLLECT;
                end
            end
            ST_RELEASE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                error = 1'b1;
                if (start) state_d = ST_COLLECT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            words_q   <= '0;
            wr_addr_q <= BASE_ADDR;
            addr_q    <= BASE_ADDR;
            data_q    <= '0;
            loaded_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            if (start_ok) begin
                hold_q    <= '0;
                words_q   <= '0;
                wr_addr_q <= BASE_ADDR;
                addr_q    <= BASE_ADDR;
            end

            // the presented address/data only change when a new word enters WRITE
            if ((state_q == ST_COLLECT) && word_full) begin
                data_q <= packed_word;
                addr_q <= wr_addr_q;
                hold_q <= '0;
            end

            if (state_q == ST_WRITE) begin
                if (hold_end) begin
                    hold_q    <= '0;
                    wr_addr_q <= next_word_addr(wr_addr_q);
                    words_q   <= words_q + WW'(1);
                end else begin
                    hold_q <= hold_q + HW'(1);
                end
            end

            if (state_d == ST_RELEASE)    loaded_q <= 1'b1;
            else if (state_d == ST_ERROR) loaded_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: table-driven sessions plus random programs,
// all compared against a word-level reference model of the load protocol.
module tb_instr_mem_loader;

    localparam int HOLD   = 2;
    localparam int O_DONE = 0;
    localparam int O_ERR  = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0] start_s, vld_s, lst_s;
    logic [7:0] dat_s [2];

    instr_mem_loader_if bus0 ();
    instr_mem_loader_if bus1 ();

    assign bus0.byte_valid = vld_s[0];
    assign bus0.byte_data  = dat_s[0];
    assign bus0.byte_last  = lst_s[0];
    assign bus1.byte_valid = vld_s[1];
    assign bus1.byte_data  = dat_s[1];
    assign bus1.byte_last  = lst_s[1];

    logic        init_w [2], cpurst_w [2], busy_w [2], done_w [2], err_w [2], rdy_w [2];
    logic [31:0] idat_w [2], iaddr_w [2];

    assign rdy_w[0] = bus0.byte_ready;
    assign rdy_w[1] = bus1.byte_ready;

    instr_mem_loader #(.MAX_WORDS(64), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .start(start_s[0]), .bus(bus0),
        .initialize(init_w[0]), .instruction_initialize_data(idat_w[0]),
        .instruction_initialize_address(iaddr_w[0]), .cpu_rst(cpurst_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .error(err_w[0])
    );

    instr_mem_loader #(.MAX_WORDS(4), .HOLD_CYCLES(HOLD)) dut_ovf (
        .clk(clk), .rst(rst), .start(start_s[1]), .bus(bus1),
        .initialize(init_w[1]), .instruction_initialize_data(idat_w[1]),
        .instruction_initialize_address(iaddr_w[1]), .cpu_rst(cpurst_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .error(err_w[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- write monitor (negedge, away from the active edge) ----------------
    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [31:0] data;
        int          len;
    } wr_t;

    wr_t         wq[$];
    logic        init_p [2]   = '{1'b0, 1'b0};
    logic        cpurst_p [2] = '{1'b0, 1'b0};
    logic [31:0] cur_a [2], cur_d [2];
    int          cur_len [2];
    int          done_cnt [2], rel_edge [2], rdy_in_write [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (init_w[k] && rdy_w[k]) rdy_in_write[k]++;
            if (done_w[k]) done_cnt[k]++;
            if (init_p[k] && !init_w[k] && cpurst_p[k] && !cpurst_w[k]) rel_edge[k]++;
            if (init_p[k] && (!init_w[k] || idat_w[k] != cur_d[k] || iaddr_w[k] != cur_a[k]))
                wq.push_back('{id: k, addr: cur_a[k], data: cur_d[k], len: cur_len[k]});
            if (init_w[k]) begin
                if (init_p[k] && idat_w[k] == cur_d[k] && iaddr_w[k] == cur_a[k]) begin
                    cur_len[k]++;
                end else begin
                    cur_len[k] = 1;
                    cur_a[k]   = iaddr_w[k];
                    cur_d[k]   = idat_w[k];
                end
            end
            init_p[k]   = init_w[k];
            cpurst_p[k] = cpurst_w[k];
        end
    end

    // ---------------- reference model: protocol rules on whole words ----------------
    byte unsigned prog[$];
    logic [31:0]  exp_q[$];
    int           model_out;

    task automatic model(input int last_idx, input int max_w);
        int k = 0;
        exp_q.delete();
        model_out = -1;
        while (model_out < 0) begin
            if (k == max_w) begin
                model_out = O_ERR;
            end else if (last_idx >= 4*k && last_idx < 4*k + 3) begin
                model_out = O_ERR;
            end else if (4*k + 3 >= prog.size()) begin
                model_out = O_ERR + 1;  // program ran out without a terminator
            end else begin
                exp_q.push_back({prog[4*k], prog[4*k+1], prog[4*k+2], prog[4*k+3]});
                k++;
                if (last_idx == 4*k - 1) model_out = O_DONE;
            end
        end
    endtask

    // ---------------- one load session ----------------
    task automatic run_session(input int sel, input int last_idx, input int gap,
                               input int restart_at, input int exp_n, input int exp_out,
                               input string tag);
        int  idx = 0, cyc = 0, acc_last = -1, end_cyc = -1, n_wr = 0;
        bit  acc, restarted = 1'b0, finished = 1'b0;
        wr_t got[$];

        model(last_idx, (sel == 1) ? 4 : 64);
        wq.delete();
        done_cnt[sel] = 0; rel_edge[sel] = 0; rdy_in_write[sel] = 0;

        start_s[sel] = 1'b1;
        @(posedge clk); #1;
        start_s[sel] = 1'b0;
        check({tag, ".busy_on_start"}, 32'(busy_w[sel]), 32'd1);
        check({tag, ".err_cleared"},   32'(err_w[sel]),  32'd0);

        while (!finished && cyc < 2000) begin
            start_s[sel] = 1'b0;
            if (idx == restart_at && !restarted) begin
                start_s[sel] = 1'b1;
                restarted    = 1'b1;
            end
            if (idx < prog.size() && !vld_s[sel] && $urandom_range(99) >= gap)
                vld_s[sel] = 1'b1;
            if (vld_s[sel]) begin
                dat_s[sel] = prog[idx];
                lst_s[sel] = (idx == last_idx);
            end
            acc = vld_s[sel] && rdy_w[sel];
            @(posedge clk); #1;
            cyc++;
            start_s[sel] = 1'b0;
            if (acc) begin
                if (idx == 3 && (last_idx < 0 || last_idx >= 3))
                    check({tag, ".first_write_latency"}, 32'(init_w[sel]), 32'd1);
                if (idx == last_idx) acc_last = cyc;
                idx++;
                vld_s[sel] = 1'b0;
                lst_s[sel] = 1'b0;
            end
            if (done_w[sel] || err_w[sel]) begin
                finished = 1'b1;
                end_cyc  = cyc;
            end
        end
        vld_s[sel] = 1'b0;
        lst_s[sel] = 1'b0;
        check({tag, ".session_ended"}, 32'(finished), 32'd1);

        repeat (6) @(posedge clk);
        #1;

        foreach (wq[i]) if (wq[i].id == sel) got.push_back(wq[i]);
        n_wr = got.size();
        check({tag, ".n_writes"}, 32'(n_wr), 32'(exp_n));
        for (int i = 0; i < n_wr && i < exp_q.size(); i++) begin
            check($sformatf("%s.addr%0d", tag, i), got[i].addr, 32'(4 * i));
            check($sformatf("%s.data%0d", tag, i), got[i].data, exp_q[i]);
            check($sformatf("%s.hold%0d", tag, i), 32'(got[i].len), 32'(HOLD));
        end
        check({tag, ".ready_in_write"}, 32'(rdy_in_write[sel]), 32'd0);
        check({tag, ".error"},   32'(err_w[sel]),    (exp_out == O_ERR) ? 32'd1 : 32'd0);
        check({tag, ".cpu_rst"}, 32'(cpurst_w[sel]), (exp_out == O_ERR) ? 32'd1 : 32'd0);
        check({tag, ".init_low"}, 32'(init_w[sel]), 32'd0);
        check({tag, ".done_pulses"}, 32'(done_cnt[sel]), (exp_out == O_DONE) ? 32'd1 : 32'd0);
        if (exp_out == O_DONE) begin
            check({tag, ".release_same_edge"}, 32'(rel_edge[sel]), 32'd1);
            check({tag, ".end_latency"}, 32'(end_cyc - acc_last), 32'(HOLD));
        end
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        int    sel;
        int    nbytes;
        int    last_idx;
        int    gap;
        int    restart_at;
        int    exp_words;
        int    exp_out;
        string name;
    } vec_t;

    vec_t vecs [8];
    byte unsigned base_prog [20] = '{8'h00, 8'h02, 8'h08, 8'h20, 8'h00, 8'h84, 8'h40, 8'h22,
                                     8'h00, 8'hA6, 8'h38, 8'h25, 8'h11, 8'h22, 8'h33, 8'h44,
                                     8'h55, 8'h66, 8'h77, 8'h88};

    initial begin
        int nw, li;
        vecs[0] = '{0, 12, 11,  0, -1, 3, O_DONE, "load"};
        vecs[1] = '{0, 12, 11, 40, -1, 3, O_DONE, "backpressure"};
        vecs[2] = '{0, 12,  5,  0, -1, 1, O_ERR,  "misaligned_last"};
        vecs[3] = '{1, 20, -1,  0, -1, 4, O_ERR,  "overflow"};
        vecs[4] = '{0, 12, 11, 30,  5, 3, O_DONE, "start_while_busy"};
        vecs[5] = '{1, 16, 15, 20, -1, 4, O_DONE, "last_fills_memory"};
        vecs[6] = '{0,  4,  3,  0, -1, 1, O_DONE, "single_word"};
        vecs[7] = '{0, 12,  8, 10, -1, 2, O_ERR,  "last_on_first_byte"};

        start_s = '0; vld_s = '0; lst_s = '0;
        dat_s[0] = '0; dat_s[1] = '0;

        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset%0d.cpu_rst", k), 32'(cpurst_w[k]), 32'd1);
            check($sformatf("reset%0d.init", k),    32'(init_w[k]),   32'd0);
            check($sformatf("reset%0d.ready", k),   32'(rdy_w[k]),    32'd0);
            check($sformatf("reset%0d.addr", k),    iaddr_w[k],       32'd0);
            check($sformatf("reset%0d.data", k),    idat_w[k],        32'd0);
            check($sformatf("reset%0d.error", k),   32'(err_w[k]),    32'd0);
            check($sformatf("reset%0d.busy", k),    32'(busy_w[k]),   32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // table-driven sessions
        foreach (vecs[v]) begin
            prog.delete();
            for (int i = 0; i < vecs[v].nbytes; i++) prog.push_back(base_prog[i]);
            run_session(vecs[v].sel, vecs[v].last_idx, vecs[v].gap, vecs[v].restart_at,
                        vecs[v].exp_words, vecs[v].exp_out, vecs[v].name);
        end

        // reset during the second WRITE cycle of word 2
        prog.delete();
        for (int i = 0; i < 12; i++) prog.push_back(base_prog[i]);
        begin
            int  idx = 0, cyc = 0;
            bit  acc;
            start_s[0] = 1'b1;
            @(posedge clk); #1;
            start_s[0] = 1'b0;
            while (!(init_w[0] && iaddr_w[0] == 32'd4) && cyc < 200) begin
                vld_s[0] = 1'b1;
                dat_s[0] = prog[idx];
                lst_s[0] = (idx == 11);
                acc = rdy_w[0];
                @(posedge clk); #1;
                cyc++;
                if (acc) idx++;
            end
            check("midrst.reached_word2", 32'(init_w[0] && iaddr_w[0] == 32'd4), 32'd1);
            @(posedge clk); #1;
            rst = 1'b1;
            vld_s[0] = 1'b0;
            lst_s[0] = 1'b0;
            @(posedge clk); #1;
            check("midrst.cpu_rst", 32'(cpurst_w[0]), 32'd1);
            check("midrst.init",    32'(init_w[0]),   32'd0);
            check("midrst.busy",    32'(busy_w[0]),   32'd0);
            check("midrst.ready",   32'(rdy_w[0]),    32'd0);
            check("midrst.addr",    iaddr_w[0],       32'd0);
            check("midrst.data",    idat_w[0],        32'd0);
            check("midrst.error",   32'(err_w[0]),    32'd0);
            rst = 1'b0;
            @(posedge clk); #1;
        end
        run_session(0, 11, 25, 2, 3, O_DONE, "reload_after_rst");

        // randomized programs against the reference model
        for (int r = 0; r < 8; r++) begin
            int sel;
            sel = int'($urandom_range(1));
            nw  = int'($urandom_range(6, 1));
            prog.delete();
            for (int i = 0; i < 4 * nw; i++) prog.push_back(8'($urandom));
            li = ($urandom_range(3) == 0) ? int'($urandom_range(4 * nw - 1)) : 4 * nw - 1;
            model(li, (sel == 1) ? 4 : 64);
            nw = exp_q.size();
            run_session(sel, li, int'($urandom_range(60)), int'($urandom_range(15)), nw,
                        model_out, $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
